// File: rtl/trig_pkg.sv
// Shared widths and types for the trig lookup path (sin_cos and its clients).
package trig_pkg;

    localparam int unsigned PHASE_W = 10;
    localparam int unsigned TRIG_W  = 18;

    typedef logic signed [TRIG_W-1:0] trig_t;
    typedef logic [PHASE_W-1:0]       phase_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched upward from a rotating pointer.
module rr_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic             advance,
    output logic [N_REQ-1:0] grant,
    output logic [IDX_W-1:0] index
);

    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] cand_idx;
    logic             found;
    int               cand;

    // Scan pointer, pointer+1, ... with wrap; the first requesting slot wins.
    always_comb begin
        grant    = '0;
        index    = '0;
        found    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int off = 0; off < int'(N_REQ); off++) begin
            cand = int'(ptr_q) + off;
            if (cand >= int'(N_REQ)) begin
                cand = cand - int'(N_REQ);
            end
            cand_idx = IDX_W'(cand);
            if (!found && req[cand_idx]) begin
                found           = 1'b1;
                grant[cand_idx] = 1'b1;
                index           = cand_idx;
            end
        end
    end

    // Pointer moves just past the winner on each accept, otherwise holds.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= (index == IDX_W'(N_REQ - 1)) ? '0 : index + IDX_W'(1);
        end
    end

endmodule

// File: rtl/trig_lookup_arbiter.sv
// Time-shares one sin_cos lookup among N_REQ requesters; a tag pipeline
// matching the sin_cos latency routes each result back to its owner.
module trig_lookup_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned PHASE_W = trig_pkg::PHASE_W,
    parameter int unsigned TRIG_W  = trig_pkg::TRIG_W,
    parameter int unsigned LAT     = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*PHASE_W-1:0]  req_phase,
    output logic [N_REQ-1:0]          req_ready,
    output logic [PHASE_W-1:0]        trig_phase,
    input  logic signed [TRIG_W-1:0]  trig_sin,
    input  logic signed [TRIG_W-1:0]  trig_cos,
    output logic [N_REQ-1:0]          rsp_valid,
    output logic signed [TRIG_W-1:0]  rsp_sin,
    output logic signed [TRIG_W-1:0]  rsp_cos,
    output logic                      busy
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    logic [N_REQ-1:0]          req_masked;
    logic [N_REQ-1:0]          grant;
    logic [IDX_W-1:0]          grant_idx;
    logic                      accept;
    logic [PHASE_W-1:0]        sel_phase;
    logic [PHASE_W-1:0]        trig_phase_q;
    logic [LAT:0]              tag_valid_q;
    logic [LAT:0][IDX_W-1:0]   tag_idx_q;
    logic signed [TRIG_W-1:0]  rsp_sin_q;
    logic signed [TRIG_W-1:0]  rsp_cos_q;

    // No grants while disabled or in reset; in-flight tags are unaffected by enable.
    assign req_masked = req_valid & {N_REQ{enable & ~reset}};
    assign req_ready  = grant;
    assign accept     = |grant;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .req     (req_masked),
        .advance (accept),
        .grant   (grant),
        .index   (grant_idx)
    );

    // Mux the granted requester's phase onto the shared lookup.
    always_comb begin
        sel_phase = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (grant[i]) begin
                sel_phase = req_phase[i*PHASE_W +: PHASE_W];
            end
        end
    end

    // Phase register, owner-tag pipeline and result capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            trig_phase_q <= '0;
            tag_valid_q  <= '0;
            tag_idx_q    <= '0;
            rsp_sin_q    <= '0;
            rsp_cos_q    <= '0;
        end else begin
            if (accept) begin
                trig_phase_q <= sel_phase;
            end
            tag_valid_q[0] <= accept;
            tag_idx_q[0]   <= grant_idx;
            for (int i = 1; i <= int'(LAT); i++) begin
                tag_valid_q[i] <= tag_valid_q[i-1];
                tag_idx_q[i]   <= tag_idx_q[i-1];
            end
            // Stage LAT-1 is about to move into the strobe stage: its lookup is valid now.
            if (tag_valid_q[LAT-1]) begin
                rsp_sin_q <= trig_sin;
                rsp_cos_q <= trig_cos;
            end
        end
    end

    // The final tag stage is aligned with the captured result; decode its owner.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            rsp_valid[i] = tag_valid_q[LAT] && (tag_idx_q[LAT] == IDX_W'(i));
        end
    end

    assign trig_phase = trig_phase_q;
    assign rsp_sin    = rsp_sin_q;
    assign rsp_cos    = rsp_cos_q;
    assign busy       = |tag_valid_q;

endmodule

// File: tb/tb_trig_lookup_arbiter.sv
// Directed bench for trig_lookup_arbiter with a combinational sin_cos stand-in (LAT=1).
module tb_trig_lookup_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned PW = 10;
    localparam int unsigned TW = 18;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic [N-1:0]         req_valid;
    logic [N*PW-1:0]      req_phase;
    logic [N-1:0]         req_ready;
    logic [PW-1:0]        trig_phase;
    logic signed [TW-1:0] trig_sin;
    logic signed [TW-1:0] trig_cos;
    logic [N-1:0]         rsp_valid;
    logic signed [TW-1:0] rsp_sin;
    logic signed [TW-1:0] rsp_cos;
    logic                 busy;

    int checks = 0;
    int failures = 0;

    // Stand-in lookup tables: distinct, nonzero and partly negative per phase.
    function automatic logic signed [TW-1:0] msin(input logic [PW-1:0] p);
        logic [TW-1:0] v;
        v = {p, 8'h3C} ^ 18'h2A5A5;
        return signed'(v);
    endfunction

    function automatic logic signed [TW-1:0] mcos(input logic [PW-1:0] p);
        logic [TW-1:0] v;
        v = {~p, 8'hC3} + 18'd1234;
        return signed'(v);
    endfunction

    assign trig_sin = msin(trig_phase);
    assign trig_cos = mcos(trig_phase);

    trig_lookup_arbiter #(
        .N_REQ   (N),
        .PHASE_W (PW),
        .TRIG_W  (TW),
        .LAT     (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .req_valid  (req_valid),
        .req_phase  (req_phase),
        .req_ready  (req_ready),
        .trig_phase (trig_phase),
        .trig_sin   (trig_sin),
        .trig_cos   (trig_cos),
        .rsp_valid  (rsp_valid),
        .rsp_sin    (rsp_sin),
        .rsp_cos    (rsp_cos),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b1; req_valid = 4'b1111;
        req_phase = {10'h300, 10'h200, 10'h100, 10'h000};
        #1;
        checks++; if (req_ready !== 4'b0000) begin failures++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
        checks++; if (trig_phase !== 10'h000) begin failures++; $display("FAIL reset_phase got=%h exp=000", trig_phase); end
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0000", rsp_valid); end
        checks++; if (rsp_sin !== 18'sd0 || rsp_cos !== 18'sd0) begin failures++; $display("FAIL reset_rsp got=%h/%h exp=0/0", rsp_sin, rsp_cos); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
        step();
        reset = 1'b0; req_valid = 4'b0000;
        step();
    endtask

    task automatic test_single();
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (trig_phase !== 10'h000) begin failures++; $display("FAIL single_phase got=%h exp=000", trig_phase); end
        checks++; if (busy !== 1'b1 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL single_t1 got busy=%b rv=%b exp busy=1 rv=0000", busy, rsp_valid); end
        step();
        checks++; if (rsp_valid !== 4'b0001) begin failures++; $display("FAIL single_rsp_valid got=%b exp=0001", rsp_valid); end
        checks++; if (rsp_sin !== msin(10'h000) || rsp_cos !== mcos(10'h000)) begin failures++; $display("FAIL single_rsp got=%h/%h exp=%h/%h", rsp_sin, rsp_cos, msin(10'h000), mcos(10'h000)); end
        step();
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL single_drain got rv=%b busy=%b exp rv=0000 busy=0", rsp_valid, busy); end
        checks++; if (rsp_sin !== msin(10'h000)) begin failures++; $display("FAIL single_hold got=%h exp=%h", rsp_sin, msin(10'h000)); end
    endtask

    task automatic test_round_robin();
        logic [N-1:0]  exp_rdy;
        logic [N-1:0]  exp_rv;
        logic [PW-1:0] ep;
        pulse_reset();
        req_phase = {10'h300, 10'h200, 10'h100, 10'h000};
        for (int c = 0; c < 7; c++) begin
            req_valid = (c < 5) ? 4'b1111 : 4'b0000;
            #1;
            exp_rdy = (c < 5) ? 4'(1 << (c % 4)) : 4'b0000;
            checks++; if (req_ready !== exp_rdy) begin failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, req_ready, exp_rdy); end
            if (c >= 2) begin
                exp_rv = 4'(1 << ((c - 2) % 4));
                ep = PW'(((c - 2) % 4) * 256);
                checks++; if (rsp_valid !== exp_rv) begin failures++; $display("FAIL rr_rsp_valid c=%0d got=%b exp=%b", c, rsp_valid, exp_rv); end
                checks++; if (rsp_sin !== msin(ep)) begin failures++; $display("FAIL rr_rsp_sin c=%0d got=%h exp=%h", c, rsp_sin, msin(ep)); end
            end
            step();
        end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rr_busy_end got=%b exp=0", busy); end
    endtask

    task automatic test_fairness();
        pulse_reset();
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL fair_setup got=%b exp=0010", req_ready); end
        step();
        req_valid = 4'b0000;
        step(); step();
        req_phase = {10'h3AB, 10'h200, 10'h100, 10'h055};
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin failures++; $display("FAIL fair_first got=%b exp=1000", req_ready); end
        step();
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL fair_second got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (rsp_valid !== 4'b1000 || rsp_sin !== msin(10'h3AB)) begin failures++; $display("FAIL fair_rsp3 got rv=%b sin=%h exp rv=1000 sin=%h", rsp_valid, rsp_sin, msin(10'h3AB)); end
        step();
        checks++; if (rsp_valid !== 4'b0001 || rsp_cos !== mcos(10'h055)) begin failures++; $display("FAIL fair_rsp0 got rv=%b cos=%h exp rv=0001 cos=%h", rsp_valid, rsp_cos, mcos(10'h055)); end
        step();
    endtask

    task automatic test_enable();
        enable = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (req_ready !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL en_off c=%0d got rdy=%b busy=%b exp rdy=0000 busy=0", c, req_ready, busy); end
            step();
        end
        req_phase[1*PW +: PW] = 10'h1C7;
        req_valid = 4'b0010;
        enable = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL en_grant got=%b exp=0010", req_ready); end
        step();
        enable = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || req_ready !== 4'b0000) begin failures++; $display("FAIL en_inflight got busy=%b rdy=%b exp busy=1 rdy=0000", busy, req_ready); end
        step();
        checks++; if (rsp_valid !== 4'b0010 || rsp_sin !== msin(10'h1C7) || busy !== 1'b1) begin failures++; $display("FAIL en_strobe got rv=%b sin=%h busy=%b exp rv=0010 sin=%h busy=1", rsp_valid, rsp_sin, busy, msin(10'h1C7)); end
        step();
        checks++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL en_drain got rv=%b busy=%b exp rv=0000 busy=0", rsp_valid, busy); end
        req_valid = 4'b0000;
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        req_phase[2*PW +: PW] = 10'h2EE;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin failures++; $display("FAIL rmid_grant got=%b exp=0100", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (busy !== 1'b1 || trig_phase !== 10'h2EE) begin failures++; $display("FAIL rmid_pre got busy=%b ph=%h exp busy=1 ph=2EE", busy, trig_phase); end
        reset = 1'b1;
        #1;
        checks++; if (trig_phase !== 10'h000 || busy !== 1'b0) begin failures++; $display("FAIL rmid_async got ph=%h busy=%b exp ph=000 busy=0", trig_phase, busy); end
        checks++; if (rsp_sin !== 18'sd0 || rsp_cos !== 18'sd0 || rsp_valid !== 4'b0000) begin failures++; $display("FAIL rmid_rsp got=%h/%h rv=%b exp=0/0 rv=0000", rsp_sin, rsp_cos, rsp_valid); end
        step();
        checks++; if (rsp_valid !== 4'b0000) begin failures++; $display("FAIL rmid_nostrobe got=%b exp=0000", rsp_valid); end
        reset = 1'b0;
        req_phase = {10'h333, 10'h200, 10'h0F0, 10'h000};
        req_valid = 4'b1010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin failures++; $display("FAIL rmid_ptr0 got=%b exp=0010", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (trig_phase !== 10'h0F0) begin failures++; $display("FAIL rmid_phase got=%h exp=0F0", trig_phase); end
        step();
        checks++; if (rsp_valid !== 4'b0010 || rsp_sin !== msin(10'h0F0)) begin failures++; $display("FAIL rmid_rsp_after got rv=%b sin=%h exp rv=0010 sin=%h", rsp_valid, rsp_sin, msin(10'h0F0)); end
        step();
    endtask

    task automatic test_phase_change();
        enable = 1'b0;
        req_valid = 4'b0001;
        req_phase[PW-1:0] = 10'h111;
        step();
        req_phase[PW-1:0] = 10'h222;
        step();
        req_phase[PW-1:0] = 10'h3FF;
        enable = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) begin failures++; $display("FAIL pchg_grant got=%b exp=0001", req_ready); end
        step();
        req_valid = 4'b0000;
        checks++; if (trig_phase !== 10'h3FF) begin failures++; $display("FAIL pchg_phase got=%h exp=3FF", trig_phase); end
        step();
        checks++; if (rsp_valid !== 4'b0001 || rsp_sin !== msin(10'h3FF) || rsp_cos !== mcos(10'h3FF)) begin failures++; $display("FAIL pchg_rsp got rv=%b %h/%h exp rv=0001 %h/%h", rsp_valid, rsp_sin, rsp_cos, msin(10'h3FF), mcos(10'h3FF)); end
        step();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; req_valid = '0; req_phase = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_fairness();
        test_enable();
        test_reset_mid();
        test_phase_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
